apb_protocol_monitor: RTL and testbench

//  Passive, synthesizable APB3 bus monitor for one shared APB segment with NUM_SLAVES select lines.

---
 rtl/apb_mon_pkg.sv | 30 +++
 rtl/apb_mon_sat_counter.sv | 24 ++
 rtl/apb_protocol_monitor.sv | 168 ++++++++++++++++
 tb/tb_apb_protocol_monitor.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_mon_pkg.sv
// rtl/apb_mon_pkg.sv - shared types, violation indices and width helper for the APB monitor
// Purpose: common definitions imported by apb_protocol_monitor and its bench.
// Contents: state_t (IDLE/ACCESS), violation bit indices, NUM_VIOL, min_width().
package apb_mon_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int V_MULTI_SEL        = 0;
    localparam int V_ENABLE_NO_SETUP  = 1;
    localparam int V_NO_ENABLE        = 2;
    localparam int V_UNSTABLE         = 3;
    localparam int V_TIMEOUT          = 4;
    localparam int V_SLVERR_STRAY     = 5;
    localparam int V_SEL_DROP         = 6;
    localparam int NUM_VIOL           = 7;

    // ceil(log2(n)), never below 1 so a single-slave bus still gets a 1-bit index
    function automatic int min_width(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/apb_mon_sat_counter.sv
// rtl/apb_mon_sat_counter.sv - saturating event counter with synchronous clear
// Purpose: counts inc pulses, sticking at all-ones.
// Ports: clk, rst (sync active-high), clr (sync clear, beats inc), inc, count[W-1:0].
module apb_mon_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/apb_protocol_monitor.sv
// rtl/apb_protocol_monitor.sv - passive APB3 protocol monitor with transfer reports and stats
// Purpose: watches one APB segment, flags protocol violations (pulse + sticky),
//          reports each completed transfer and keeps saturating rd/wr/slverr counts.
// Ports: pclk/preset (sync active-high); APB inputs psel, penable, pwrite, paddr,
//        pwdata, prdata, pready, pslverr; clr clears sticky bits and counters;
//        viol_pulse/viol_sticky; txn_* transfer report; wr/rd/err_count.
module apb_protocol_monitor
    import apb_mon_pkg::*;
#(
    parameter  int ADDR_WIDTH     = 8,
    parameter  int DATA_WIDTH     = 16,
    parameter  int NUM_SLAVES     = 2,
    parameter  int TIMEOUT_CYCLES = 16,
    parameter  int COUNT_WIDTH    = 16,
    localparam int SEL_W          = min_width(NUM_SLAVES),
    localparam int WAIT_W         = min_width(TIMEOUT_CYCLES + 1)
) (
    input  logic                   pclk,
    input  logic                   preset,
    input  logic [NUM_SLAVES-1:0]  psel,
    input  logic                   penable,
    input  logic                   pwrite,
    input  logic [ADDR_WIDTH-1:0]  paddr,
    input  logic [DATA_WIDTH-1:0]  pwdata,
    input  logic [DATA_WIDTH-1:0]  prdata,
    input  logic                   pready,
    input  logic                   pslverr,
    input  logic                   clr,
    output logic [NUM_VIOL-1:0]    viol_pulse,
    output logic [NUM_VIOL-1:0]    viol_sticky,
    output logic                   txn_valid,
    output logic                   txn_write,
    output logic [ADDR_WIDTH-1:0]  txn_addr,
    output logic [DATA_WIDTH-1:0]  txn_data,
    output logic                   txn_slverr,
    output logic [SEL_W-1:0]       txn_sel_idx,
    output logic [WAIT_W-1:0]      txn_waits,
    output logic [COUNT_WIDTH-1:0] wr_count,
    output logic [COUNT_WIDTH-1:0] rd_count,
    output logic [COUNT_WIDTH-1:0] err_count
);

    state_t                  r_state;
    logic [NUM_SLAVES-1:0]   r_sel;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_write;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [WAIT_W-1:0]       r_waits;

    state_t                  w_next;
    logic                    w_multi;
    logic                    w_onehot;
    logic                    w_start;
    logic                    w_complete;
    logic [WAIT_W-1:0]       w_waits_inc;
    logic [NUM_VIOL-1:0]     w_viol;
    logic [SEL_W-1:0]        w_sel_idx;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign w_multi     = (psel & (psel - NUM_SLAVES'(1))) != '0;
    assign w_onehot    = (psel != '0) && !w_multi;
    assign w_waits_inc = r_waits + WAIT_W'(1);

    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_complete = 1'b0;
        w_viol     = '0;
        w_viol[V_MULTI_SEL] = w_multi;
        case (r_state)
            IDLE: begin
                if ((psel != '0) && penable) begin
                    w_viol[V_ENABLE_NO_SETUP] = 1'b1;
                end else if (w_onehot) begin
                    w_start = 1'b1;
                    w_next  = ACCESS;
                end
            end
            ACCESS: begin
                w_next = IDLE;
                if (psel == '0) begin
                    w_viol[V_SEL_DROP] = 1'b1;
                end else if (!penable) begin
                    // Missing enable right after setup is its own class; dropping it
                    // while waiting means the bus changed under a live transfer.
                    if (r_waits == '0) begin
                        w_viol[V_NO_ENABLE] = 1'b1;
                    end else begin
                        w_viol[V_UNSTABLE] = 1'b1;
                    end
                end else if (w_multi || (psel != r_sel) || (paddr != r_addr) ||
                             (pwrite != r_write) || (r_write && (pwdata != r_wdata))) begin
                    w_viol[V_UNSTABLE] = 1'b1;
                end else if (pready) begin
                    w_complete = 1'b1;
                end else if (w_waits_inc == WAIT_W'(TIMEOUT_CYCLES)) begin
                    w_viol[V_TIMEOUT] = 1'b1;
                end else begin
                    w_next = ACCESS;
                end
            end
            default: w_next = IDLE;
        endcase
        w_viol[V_SLVERR_STRAY] = pslverr && !w_complete;
    end

    always_comb begin
        w_sel_idx = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_sel[i]) begin
                w_sel_idx = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state     <= IDLE;
            r_sel       <= '0;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_waits     <= '0;
            viol_pulse  <= '0;
            viol_sticky <= '0;
            txn_valid   <= 1'b0;
            txn_write   <= 1'b0;
            txn_addr    <= '0;
            txn_data    <= '0;
            txn_slverr  <= 1'b0;
            txn_sel_idx <= '0;
            txn_waits   <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_sel   <= psel;
                r_addr  <= paddr;
                r_write <= pwrite;
                r_wdata <= pwdata;
                r_waits <= '0;
            end else if ((r_state == ACCESS) && (w_next == ACCESS)) begin
                r_waits <= w_waits_inc;
            end
            viol_pulse  <= w_viol;
            viol_sticky <= clr ? '0 : (viol_sticky | w_viol);
            txn_valid   <= w_complete;
            if (w_complete) begin
                txn_write   <= r_write;
                txn_addr    <= r_addr;
                txn_data    <= r_write ? r_wdata : prdata;
                txn_slverr  <= pslverr;
                txn_sel_idx <= w_sel_idx;
                txn_waits   <= r_waits;
            end
        end
    end

    apb_mon_sat_counter #(.W(COUNT_WIDTH)) u_wr_cnt (
        .clk(pclk), .rst(preset), .clr(clr), .inc(w_complete && r_write), .count(wr_count)
    );
    apb_mon_sat_counter #(.W(COUNT_WIDTH)) u_rd_cnt (
        .clk(pclk), .rst(preset), .clr(clr), .inc(w_complete && !r_write), .count(rd_count)
    );
    apb_mon_sat_counter #(.W(COUNT_WIDTH)) u_err_cnt (
        .clk(pclk), .rst(preset), .clr(clr), .inc(w_complete && pslverr), .count(err_count)
    );

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// tb/tb_apb_protocol_monitor.sv - scoreboard bench for apb_protocol_monitor
module tb_apb_protocol_monitor;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int NS = 2;
    localparam int TO = 16;
    localparam int CW = 16;
    localparam int CWS = 3;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic          preset, penable, pwrite, pready, pslverr, clr;
    logic [NS-1:0] psel;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, prdata;

    logic [6:0]    viol_pulse, viol_sticky;
    logic          txn_valid, txn_write, txn_slverr;
    logic [AW-1:0] txn_addr;
    logic [DW-1:0] txn_data;
    logic [0:0]    txn_sel_idx;
    logic [4:0]    txn_waits;
    logic [CW-1:0] wr_count, rd_count, err_count;

    logic [6:0]     s_viol_pulse, s_viol_sticky;
    logic           s_txn_valid, s_txn_write, s_txn_slverr;
    logic [AW-1:0]  s_txn_addr;
    logic [DW-1:0]  s_txn_data;
    logic [0:0]     s_txn_sel_idx;
    logic [4:0]     s_txn_waits;
    logic [CWS-1:0] s_wr_count, s_rd_count, s_err_count;

    apb_protocol_monitor #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS),
                           .TIMEOUT_CYCLES(TO), .COUNT_WIDTH(CW)) dut (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .clr(clr), .viol_pulse(viol_pulse), .viol_sticky(viol_sticky), .txn_valid(txn_valid),
        .txn_write(txn_write), .txn_addr(txn_addr), .txn_data(txn_data), .txn_slverr(txn_slverr),
        .txn_sel_idx(txn_sel_idx), .txn_waits(txn_waits), .wr_count(wr_count),
        .rd_count(rd_count), .err_count(err_count)
    );

    apb_protocol_monitor #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS),
                           .TIMEOUT_CYCLES(TO), .COUNT_WIDTH(CWS)) dut_small (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .clr(clr), .viol_pulse(s_viol_pulse), .viol_sticky(s_viol_sticky), .txn_valid(s_txn_valid),
        .txn_write(s_txn_write), .txn_addr(s_txn_addr), .txn_data(s_txn_data),
        .txn_slverr(s_txn_slverr), .txn_sel_idx(s_txn_sel_idx), .txn_waits(s_txn_waits),
        .wr_count(s_wr_count), .rd_count(s_rd_count), .err_count(s_err_count)
    );

    typedef struct {
        bit        is_txn;
        bit [6:0]  viol;
        bit        wr;
        bit [7:0]  addr;
        bit [15:0] data;
        bit        err;
        int        idx;
        int        waits;
    } ev_t;

    ev_t      exp_q[$];
    ev_t      mon_e;
    int       total = 0;
    int       bad = 0;
    int       m_wr = 0, m_rd = 0, m_err = 0;
    bit [6:0] m_sticky = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic longint sat(input int n, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (n > mx) ? mx : longint'(n);
    endfunction

    // Scoreboard: every cycle that shows a report or a violation consumes one expectation.
    always @(negedge pclk) begin
        if (txn_valid === 1'b1 || viol_pulse !== 7'd0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {txn_valid, viol_pulse}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("viol_pulse", viol_pulse, mon_e.viol);
                check("txn_valid", txn_valid, mon_e.is_txn);
                if (mon_e.is_txn) begin
                    check("txn_write", txn_write, mon_e.wr);
                    check("txn_addr", txn_addr, mon_e.addr);
                    check("txn_data", txn_data, mon_e.data);
                    check("txn_slverr", txn_slverr, mon_e.err);
                    check("txn_sel_idx", txn_sel_idx, mon_e.idx);
                    check("txn_waits", txn_waits, mon_e.waits);
                end
            end
        end
    end

    task automatic push_viol(input bit [6:0] v);
        ev_t e;
        e.is_txn = 1'b0; e.viol = v; e.wr = 1'b0; e.addr = '0; e.data = '0;
        e.err = 1'b0; e.idx = 0; e.waits = 0;
        exp_q.push_back(e);
        m_sticky |= v;
    endtask

    task automatic push_txn(input bit wr, input bit [7:0] a, input bit [15:0] d,
                            input bit err, input int idx, input int nw);
        ev_t e;
        e.is_txn = 1'b1; e.viol = '0; e.wr = wr; e.addr = a; e.data = d;
        e.err = err; e.idx = idx; e.waits = nw;
        exp_q.push_back(e);
        if (wr) m_wr++; else m_rd++;
        if (err) m_err++;
    endtask

    task automatic cyc(input logic [NS-1:0] s, input logic en, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                       input logic rdy, input logic err);
        psel = s; penable = en; pwrite = wr; paddr = a;
        pwdata = wd; prdata = rd; pready = rdy; pslverr = err;
        @(posedge pclk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc('0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    // fault: 0 clean, 1 address changes on the second wait, 2 pready never comes
    task automatic xfer(input int idx, input bit wr, input bit [7:0] a, input bit [15:0] wd,
                        input bit [15:0] rd, input int nw, input bit err, input int fault);
        logic [NS-1:0] s;
        s = NS'(1) << idx;
        cyc(s, 1'b0, wr, a, wd, rd, 1'b0, 1'b0);
        if (fault == 2) begin
            for (int i = 0; i < TO; i++) begin
                if (i == TO - 1) push_viol(7'h10);
                cyc(s, 1'b1, wr, a, wd, rd, 1'b0, 1'b0);
            end
            idle(1);
            return;
        end
        for (int i = 0; i < nw; i++) begin
            if (fault == 1 && i == 1) begin
                push_viol(7'h08);
                cyc(s, 1'b1, wr, a ^ 8'h01, wd, rd, 1'b0, 1'b0);
                idle(1);
                return;
            end
            cyc(s, 1'b1, wr, a, wd, rd, 1'b0, 1'b0);
        end
        push_txn(wr, a, wr ? wd : rd, err, idx, nw);
        cyc(s, 1'b1, wr, a, wd, rd, 1'b1, err);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_wr"},    wr_count,    sat(m_wr, CW));
        check({tag, "_rd"},    rd_count,    sat(m_rd, CW));
        check({tag, "_err"},   err_count,   sat(m_err, CW));
        check({tag, "_s_wr"},  s_wr_count,  sat(m_wr, CWS));
        check({tag, "_s_rd"},  s_rd_count,  sat(m_rd, CWS));
        check({tag, "_s_err"}, s_err_count, sat(m_err, CWS));
    endtask

    task automatic do_clr();
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        m_wr = 0; m_rd = 0; m_err = 0; m_sticky = '0;
    endtask

    initial begin
        int kind, nw;
        preset = 1'b1; clr = 1'b0;
        idle(3);
        preset = 1'b0;
        check("rst_viol_pulse", viol_pulse, 7'd0);
        check("rst_sticky", viol_sticky, 7'd0);
        check("rst_txn_valid", txn_valid, 1'b0);
        check("rst_txn_addr", txn_addr, 8'd0);
        check("rst_txn_data", txn_data, 16'd0);
        check_counts("rst");

        xfer(0, 1'b1, 8'h12, 16'hBEEF, 16'h0000, 0, 1'b0, 0);
        idle(1);
        check_counts("t1");

        xfer(1, 1'b0, 8'h05, 16'h1111, 16'h00A5, 3, 1'b1, 0);
        idle(1);
        check_counts("t2");
        check("t2_sticky", viol_sticky, m_sticky);

        xfer(0, 1'b0, 8'h20, 16'h0000, 16'h3C3C, 3, 1'b0, 1);
        check("t3_sticky", viol_sticky, m_sticky);
        xfer(1, 1'b1, 8'h30, 16'h5A5A, 16'h0000, 1, 1'b0, 0);
        idle(1);
        check_counts("t3");

        push_viol(7'h20);
        cyc('0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
        idle(1);
        check("stray_sticky", viol_sticky, m_sticky);

        do_clr();
        push_viol(7'h01);
        cyc(2'b11, 1'b0, 1'b0, 8'h40, '0, '0, 1'b0, 1'b0);
        push_viol(7'h02);
        cyc(2'b01, 1'b1, 1'b0, 8'h41, '0, '0, 1'b0, 1'b0);
        idle(1);
        check("t4_sticky", viol_sticky, m_sticky);
        check("t4_sticky_s", s_viol_sticky, m_sticky);
        do_clr();
        check("t4_clr_sticky", viol_sticky, 7'd0);
        check_counts("t4_clr");

        xfer(1, 1'b1, 8'h50, 16'h7777, 16'h0000, 0, 1'b0, 2);
        check("t5_sticky", viol_sticky, m_sticky);
        xfer(0, 1'b0, 8'h51, 16'h0000, 16'h1234, 15, 1'b0, 0);

        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 9);
            nw = (kind == 2) ? 15 : $urandom_range(0, 4);
            if (kind == 0) begin
                push_viol(7'h20);
                cyc('0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
            end else begin
                xfer($urandom_range(0, 1), 1'($urandom_range(0, 1)), 8'($urandom),
                     16'($urandom), 16'($urandom), (kind == 1) ? 3 : nw,
                     1'($urandom_range(0, 3) == 0), (kind == 1) ? 1 : 0);
            end
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(1);
        check_counts("rand");
        check("rand_sticky", viol_sticky, m_sticky);

        cyc(2'b01, 1'b0, 1'b1, 8'h60, 16'hAAAA, '0, 1'b0, 1'b0);
        cyc(2'b01, 1'b1, 1'b1, 8'h60, 16'hAAAA, '0, 1'b0, 1'b0);
        cyc(2'b01, 1'b1, 1'b1, 8'h60, 16'hAAAA, '0, 1'b0, 1'b0);
        preset = 1'b1;
        cyc(2'b01, 1'b1, 1'b1, 8'h60, 16'hAAAA, '0, 1'b0, 1'b0);
        preset = 1'b0;
        m_wr = 0; m_rd = 0; m_err = 0; m_sticky = '0;
        idle(2);
        check("t6_rst_sticky", viol_sticky, 7'd0);
        check("t6_rst_txn_addr", txn_addr, 8'd0);
        check_counts("t6_rst");
        for (int i = 0; i < (1 << CWS) + 1; i++) begin
            xfer(i % 2, 1'b1, 8'(i), 16'(i * 3), 16'h0, i % 3, 1'b0, 0);
        end
        idle(1);
        check_counts("t6_sat");
        check("t6_s_wr_allones", s_wr_count, 3'b111);

        idle(3);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
